tlp_compl_scheduler: RTL and testbench
======================================

TLP_COMPL_SCHEDULER -- requirements
Module: tlp_compl_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, 3, number of completion requesters (fixed at 3: 0=register read, 1=config, 2=ADC memory).
REQ-002 The block SHALL have parameter TIMEOUT, 1024, cycle limit in ISSUE or WAIT_DONE before abort (legal range 2..65535).
REQ-003 The block SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port sched_en  in  1  1 = new grants allowed.
REQ-006 The block SHALL have port rq_valid  in  3  per-requester completion request.
REQ-007 The block SHALL have port rq_ready  out  3  one-hot accept pulse to the granted requester.
REQ-008 The block SHALL have port rq_code  in  9  3-bit completion code per requester, slice i = [3i+2:3i].
REQ-009 The block SHALL have port rq_desc  in  180  60-bit descriptor per requester, slice i = [60i+59:60i], packed {tc[2:0], attr[1:0], len[9:0], rid[15:0], tag[7:0], be[7:0], addr[12:0]}.
REQ-010 The block SHALL have port req_compl  out  1  completion request to the TLP encoder.
REQ-011 The block SHALL have port compl_code  out  3  code of the issued request.
REQ-012 The block SHALL have ports tenc_tc(3), tenc_attr(2), tenc_len(10), tenc_rid(16), tenc_tag(8), tenc_be(8), tenc_addr(13)  out  descriptor fields to the encoder.
REQ-013 The block SHALL have port tlp_encoder_ready  in  1  encoder idle (1) / busy (0).
REQ-014 The block SHALL have port compl_done  out  1  one-cycle pulse per finished completion.
REQ-015 The block SHALL have port err_timeout  out  1  sticky abort flag.
REQ-016 The block SHALL have port compl_cnt  out  16  finished-completion counter.
REQ-017 The block SHALL have port busy  out  1  1 whenever state != IDLE.

Function
REQ-018 The block SHALL implement states IDLE, ISSUE and WAIT_DONE; all outputs SHALL be registered.
REQ-019 IDLE: when sched_en=1, tlp_encoder_ready=1 and any rq_valid=1, the block SHALL grant one requester by round-robin, starting at (last_grant+1) mod 3.
REQ-020 On grant, rq_ready[i] SHALL pulse for exactly one cycle, rq_code/rq_desc slice i SHALL be latched onto compl_code/tenc_*, last_grant SHALL be updated, and the state SHALL go to ISSUE.
REQ-021 ISSUE: req_compl SHALL be 1; on the first cycle tlp_encoder_ready=0 is sampled, req_compl SHALL be 0 next cycle and the state SHALL go to WAIT_DONE.
REQ-022 WAIT_DONE: on tlp_encoder_ready=1, the block SHALL pulse compl_done for one cycle, increment compl_cnt (mod 2^16 wrap) and return to IDLE.
REQ-023 compl_code and tenc_* SHALL stay constant from grant until the return to IDLE; the encoder samples tenc_be/tenc_addr after dropping ready.
REQ-024 A 16-bit timeout counter SHALL clear on entry to ISSUE and WAIT_DONE and increment each cycle in those states.
REQ-025 When the timeout counter reaches TIMEOUT-1, the block SHALL set err_timeout, drop req_compl, return to IDLE, and leave compl_done and compl_cnt unchanged.
REQ-026 err_timeout SHALL clear only on reset.
REQ-027 sched_en=0 SHALL block new grants only; an in-flight request SHALL complete normally.
REQ-028 rq_valid deasserted after its grant SHALL have no effect; rq_valid high with no grant SHALL be held, with no drop and no duplicate.
REQ-029 At most one requester SHALL be granted per IDLE visit; a grant SHALL not occur in the same cycle compl_done pulses, so the minimum gap between grants is 1 IDLE cycle.
REQ-030 The block SHALL grant nothing in IDLE while tlp_encoder_ready=0.

Reset
REQ-031 While reset=1, the state SHALL be IDLE, last_grant=2, and rq_ready, req_compl, compl_code, tenc_*, compl_done, err_timeout, compl_cnt and busy SHALL all be 0.
REQ-032 Reset asserted in ISSUE or WAIT_DONE SHALL abort immediately, with req_compl=0 on the cycle after reset is sampled and no compl_done.

Verification
REQ-033 Scenario: rq_valid=3'b111 held, encoder model busy 4 cycles per request -> grants in order 0,1,2,0; compl_cnt=4 after four compl_done pulses.
REQ-034 Scenario: requester 2 only, desc len=10'd8, be=8'hFF, code=3'b100 -> tenc_len=8, tenc_be=8'hFF and compl_code=3'b100 stable until compl_done; req_compl drops 1 cycle after ready=0.
REQ-035 Scenario: encoder ready never drops, TIMEOUT=16 -> err_timeout=1 at 16 cycles after ISSUE entry, state IDLE, compl_cnt unchanged; the next request is still served.
REQ-036 Scenario: sched_en=0 during WAIT_DONE with rq_valid[1]=1 -> in-flight compl_done occurs, no rq_ready until sched_en=1.
REQ-037 Scenario: reset pulsed in WAIT_DONE -> all outputs 0 next cycle; first grant after reset goes to requester 0.
REQ-038 Scenario: compl_cnt preloaded to 16'hFFFF by 65535 completions -> next compl_done yields compl_cnt=16'h0000.

Source files
------------

// File: rtl/tlp_compl_scheduler.sv
// tlp_compl_scheduler: round-robin arbiter handing completion descriptors to the TLP encoder,
// with a ready-handshake, an abort timeout and a count of finished completions.
module tlp_compl_scheduler #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sched_en,
    input  logic [NREQ-1:0]      rq_valid,
    output logic [NREQ-1:0]      rq_ready,
    input  logic [3*NREQ-1:0]    rq_code,
    input  logic [60*NREQ-1:0]   rq_desc,
    output logic                 req_compl,
    output logic [2:0]           compl_code,
    output logic [2:0]           tenc_tc,
    output logic [1:0]           tenc_attr,
    output logic [9:0]           tenc_len,
    output logic [15:0]          tenc_rid,
    output logic [7:0]           tenc_tag,
    output logic [7:0]           tenc_be,
    output logic [12:0]          tenc_addr,
    input  logic                 tlp_encoder_ready,
    output logic                 compl_done,
    output logic                 err_timeout,
    output logic [15:0]          compl_cnt,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t state, state_n;
    logic grant, done, abort, tmo;
    logic [1:0] last_grant, first, second, pick;
    logic [15:0] tcnt;
    logic [59:0] desc;

    assign {tenc_tc, tenc_attr, tenc_len, tenc_rid, tenc_tag, tenc_be, tenc_addr} = desc;

    always_comb begin
        first   = last_grant == 2'd2 ? 2'd0 : last_grant + 2'd1;
        second  = first == 2'd2 ? 2'd0 : first + 2'd1;
        pick    = rq_valid[first] ? first : rq_valid[second] ? second : last_grant;
        tmo     = tcnt == 16'(TIMEOUT - 1);
        grant   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        state_n = state;
        case (state)
            // compl_done high means we just came back from WAIT_DONE: force one idle cycle
            IDLE: begin
                grant = sched_en && tlp_encoder_ready && |rq_valid && !compl_done;
                if (grant) state_n = ISSUE;
            end
            ISSUE: begin
                if (!tlp_encoder_ready) state_n = WAIT_DONE;
                else if (tmo) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tlp_encoder_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (tmo) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 2'd2;
            rq_ready    <= '0;
            req_compl   <= 1'b0;
            compl_code  <= '0;
            desc        <= '0;
            compl_done  <= 1'b0;
            err_timeout <= 1'b0;
            compl_cnt   <= '0;
            busy        <= 1'b0;
            tcnt        <= '0;
        end else begin
            state       <= state_n;
            rq_ready    <= grant ? NREQ'(1) << pick : '0;
            req_compl   <= state_n == ISSUE;
            busy        <= state_n != IDLE;
            compl_done  <= done;
            err_timeout <= err_timeout | abort;
            tcnt        <= state_n != state ? '0 : tcnt + 16'd1;
            if (grant) begin
                last_grant <= pick;
                compl_code <= rq_code[3*pick +: 3];
                desc       <= rq_desc[60*pick +: 60];
            end
            if (done) compl_cnt <= compl_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_tlp_compl_scheduler.sv
// tb_tlp_compl_scheduler: directed checks of arbitration, handshake, timeout, reset abort
// and counter wrap, driving the encoder ready line by hand.
module tb_tlp_compl_scheduler;
    logic         clk = 0, reset = 1, sched_en = 0, tlp_encoder_ready = 1;
    logic [2:0]   rq_valid = '0;
    logic [8:0]   rq_code = '0;
    logic [179:0] rq_desc = '0;
    logic [2:0]   rq_ready, compl_code, tenc_tc;
    logic         req_compl, compl_done, err_timeout, busy;
    logic [1:0]   tenc_attr;
    logic [9:0]   tenc_len;
    logic [15:0]  tenc_rid, compl_cnt;
    logic [7:0]   tenc_tag, tenc_be;
    logic [12:0]  tenc_addr;
    int checks = 0, failures = 0;
    logic [2:0] g, acc;
    logic [2:0] exp_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    tlp_compl_scheduler #(.NREQ(3), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .sched_en(sched_en), .rq_valid(rq_valid), .rq_ready(rq_ready),
        .rq_code(rq_code), .rq_desc(rq_desc), .req_compl(req_compl), .compl_code(compl_code),
        .tenc_tc(tenc_tc), .tenc_attr(tenc_attr), .tenc_len(tenc_len), .tenc_rid(tenc_rid),
        .tenc_tag(tenc_tag), .tenc_be(tenc_be), .tenc_addr(tenc_addr),
        .tlp_encoder_ready(tlp_encoder_ready), .compl_done(compl_done),
        .err_timeout(err_timeout), .compl_cnt(compl_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(output logic [2:0] gr);
        gr = '0;
        for (int i = 0; i < 40 && gr == 0; i++) begin
            @(negedge clk);
            gr = rq_ready;
        end
        check("grant_seen", gr != 0, 1);
    endtask

    // encoder busy for busy_n cycles, then ready again; returns on the compl_done cycle
    task automatic finish(input int busy_n);
        logic seen;
        seen = 1'b0;
        tlp_encoder_ready = 1'b0;
        repeat (busy_n) @(negedge clk);
        tlp_encoder_ready = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = compl_done;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rq_ready", rq_ready, 0);
        check("rst_req_compl", req_compl, 0);
        check("rst_code", compl_code, 0);
        check("rst_len", tenc_len, 0);
        check("rst_err", err_timeout, 0);
        check("rst_cnt", compl_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", compl_done, 0);
        reset = 0;
        sched_en = 1;
        rq_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_grant(g);
            check("rr_grant", g, exp_rr[n]);
            finish(4);
            check("cnt_step", compl_cnt, n + 1);
            if (n == 3) rq_valid = '0;
            @(negedge clk);
            check("gap_no_grant", rq_ready, 0);
            check("done_pulse", compl_done, 0);
        end
        rq_valid = 3'b100;
        rq_code  = {3'b100, 3'b011, 3'b010};
        rq_desc  = {3'b101, 2'b10, 10'd8, 16'hABCD, 8'h5A, 8'hFF, 13'h1234,
                    3'b011, 2'b01, 10'd3, 16'h1111, 8'h22, 8'h0F, 13'h0333,
                    3'b001, 2'b11, 10'd1, 16'h4444, 8'h55, 8'h01, 13'h0666};
        wait_grant(g);
        check("r2_grant", g, 3'b100);
        check("r2_code", compl_code, 3'b100);
        check("r2_len", tenc_len, 8);
        check("r2_be", tenc_be, 8'hFF);
        check("r2_tc", tenc_tc, 3'b101);
        check("r2_attr", tenc_attr, 2'b10);
        check("r2_rid", tenc_rid, 16'hABCD);
        check("r2_tag", tenc_tag, 8'h5A);
        check("r2_addr", tenc_addr, 13'h1234);
        check("r2_req_on", req_compl, 1);
        tlp_encoder_ready = 0;
        rq_valid = '0;
        rq_desc  = '0;
        rq_code  = '0;
        @(negedge clk);
        check("r2_req_drop", req_compl, 0);
        check("r2_ready_pulse", rq_ready, 0);
        check("r2_busy", busy, 1);
        repeat (3) @(negedge clk);
        check("r2_be_hold", tenc_be, 8'hFF);
        finish(0);
        check("r2_code_hold", compl_code, 3'b100);
        check("r2_len_hold", tenc_len, 8);
        check("r2_cnt", compl_cnt, 5);
        rq_valid = 3'b010;
        wait_grant(g);
        check("to_grant", g, 3'b010);
        repeat (15) @(negedge clk);
        check("to_err_early", err_timeout, 0);
        check("to_req_held", req_compl, 1);
        @(negedge clk);
        check("to_err", err_timeout, 1);
        check("to_req_drop", req_compl, 0);
        check("to_busy", busy, 0);
        check("to_cnt", compl_cnt, 5);
        check("to_no_done", compl_done, 0);
        wait_grant(g);
        check("to_next_grant", g, 3'b010);
        rq_valid = '0;
        finish(2);
        check("to_next_cnt", compl_cnt, 6);
        check("to_err_sticky", err_timeout, 1);
        rq_valid = 3'b001;
        wait_grant(g);
        check("se_grant", g, 3'b001);
        tlp_encoder_ready = 0;
        rq_valid = 3'b010;
        @(negedge clk);
        sched_en = 0;
        repeat (2) @(negedge clk);
        finish(0);
        acc = '0;
        repeat (6) begin
            @(negedge clk);
            acc |= rq_ready;
        end
        check("se_blocked", acc, 0);
        sched_en = 1;
        wait_grant(g);
        check("se_resume", g, 3'b010);
        tlp_encoder_ready = 0;
        @(negedge clk);
        check("rs_wait_busy", busy, 1);
        reset = 1;
        @(negedge clk);
        check("rs_req", req_compl, 0);
        check("rs_busy", busy, 0);
        check("rs_ready", rq_ready, 0);
        check("rs_cnt", compl_cnt, 0);
        check("rs_err", err_timeout, 0);
        check("rs_code", compl_code, 0);
        check("rs_addr", tenc_addr, 0);
        check("rs_done", compl_done, 0);
        reset = 0;
        tlp_encoder_ready = 1;
        rq_valid = 3'b111;
        wait_grant(g);
        check("rs_first_grant", g, 3'b001);
        check("rs_no_done", compl_done, 0);
        rq_valid = '0;
        finish(2);
        check("rs_cnt_after", compl_cnt, 1);
        rq_valid = 3'b100;
        tlp_encoder_ready = 0;
        force dut.compl_cnt = 16'hFFFF;
        acc = '0;
        repeat (4) begin
            @(negedge clk);
            acc |= rq_ready;
        end
        release dut.compl_cnt;
        check("enc_busy_no_grant", acc, 0);
        check("cnt_preload", compl_cnt, 16'hFFFF);
        tlp_encoder_ready = 1;
        wait_grant(g);
        check("wrap_grant", g, 3'b100);
        rq_valid = '0;
        finish(1);
        check("cnt_wrap", compl_cnt, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
